ap_mult_sched: RTL and testbench

AP_MULT_SCHED -- requirements
Module: ap_mult_sched

---
 rtl/ap_mult_pkg.sv | 13 +
 rtl/ap_mult_sched_if.sv | 30 +++
 rtl/ap_rr_arb.sv | 31 +++
 rtl/ap_unsi_wall_8b_r7.sv | 25 ++
 rtl/ap_mult_sched.sv | 133 +++++++++++++
 tb/tb_ap_mult_sched.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/ap_mult_pkg.sv
// Shared constants for the approximate-multiplier scheduler.
// Operand/product widths, default requester count, id-width helper.
package ap_mult_pkg;

  localparam int OP_W     = 8;
  localparam int PROD_W   = 16;
  localparam int NREQ_DEF = 4;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ap_mult_sched_if.sv
// Request/result bundle between requesters, scheduler and consumer.
// master: requester/consumer side; slave: scheduler side.
interface ap_mult_sched_if
  import ap_mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_w(NREQ)
);

  logic [NREQ-1:0]      req_vld;
  logic [NREQ-1:0]      req_rdy;
  logic [NREQ*OP_W-1:0] req_muld;
  logic [NREQ*OP_W-1:0] req_mulr;
  logic                 res_vld;
  logic                 res_rdy;
  logic [PROD_W-1:0]    res;
  logic [IDW-1:0]       res_id;
  logic                 busy;

  modport master (
    output req_vld, req_muld, req_mulr, res_rdy,
    input  req_rdy, res_vld, res, res_id, busy
  );

  modport slave (
    input  req_vld, req_muld, req_mulr, res_rdy,
    output req_rdy, res_vld, res, res_id, busy
  );

endinterface

// File: rtl/ap_rr_arb.sv
// Combinational round-robin arbiter: searches from ptr+1 upward,
// grants nothing unless advance is high.
module ap_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    if (advance) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (req[idx] && gnt == '0) begin
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/ap_unsi_wall_8b_r7.sv
// Approximate 8x8 unsigned multiplier: columns 7 and up summed exactly,
// the seven low columns compressed by OR with no carry out of them.
module ap_unsi_wall_8b_r7 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] row;
  logic [15:0] hi;
  logic [6:0]  lo;

  always_comb begin
    row = '0;
    hi  = '0;
    lo  = '0;
    for (int i = 0; i < 8; i++) begin
      row = a[i] ? (16'(b) << i) : 16'd0;
      hi  = hi + (row & 16'hFF80);
      lo  = lo | row[6:0];
    end
    p = hi | {9'd0, lo};
  end

endmodule

// File: rtl/ap_mult_sched.sv
// NREQ requesters share one approximate multiplier via a 2-stage pipe.
// Optional AP_MULT_ERR_MON_EN adds err_cnt/err_max error monitoring.
module ap_mult_sched
  import ap_mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic           clk,
  input  logic           rst,
  ap_mult_sched_if.slave bus
`ifdef AP_MULT_ERR_MON_EN
  ,
  output logic [PROD_W-1:0] err_cnt,
  output logic [PROD_W-1:0] err_max
`endif
);

  logic              s1_vld;
  logic [OP_W-1:0]   s1_muld;
  logic [OP_W-1:0]   s1_mulr;
  logic [IDW-1:0]    s1_id;
  logic              s2_vld;
  logic [PROD_W-1:0] s2_res;
  logic [IDW-1:0]    s2_id;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt_id;
  logic [NREQ-1:0]   gnt;
  logic [OP_W-1:0]   muld_sel;
  logic [OP_W-1:0]   mulr_sel;
  logic [PROD_W-1:0] prod;
  logic              s1_load;
  logic              s2_load;
  logic              acc;

  assign s2_load = !s2_vld || bus.res_rdy;
  assign s1_load = !s1_vld || s2_load;

  ap_rr_arb #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req    (bus.req_vld),
    .ptr    (ptr),
    .advance(s1_load && !rst),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign acc         = |gnt;
  assign bus.req_rdy = gnt;

  always_comb begin
    muld_sel = '0;
    mulr_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        muld_sel = bus.req_muld[i*OP_W +: OP_W];
        mulr_sel = bus.req_mulr[i*OP_W +: OP_W];
      end
    end
  end

  ap_unsi_wall_8b_r7 u_mul (
    .a(s1_muld),
    .b(s1_mulr),
    .p(prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_muld <= '0;
      s1_mulr <= '0;
      s1_id   <= '0;
      s2_vld  <= 1'b0;
      s2_res  <= '0;
      s2_id   <= '0;
      ptr     <= IDW'(NREQ - 1);
    end else begin
      if (acc) ptr <= gnt_id;
      if (s1_load) begin
        s1_vld <= acc;
        if (acc) begin
          s1_muld <= muld_sel;
          s1_mulr <= mulr_sel;
          s1_id   <= gnt_id;
        end
      end
      if (s2_load) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_res <= prod;
          s2_id  <= s1_id;
        end
      end
    end
  end

  assign bus.res_vld = s2_vld;
  assign bus.res     = s2_res;
  assign bus.res_id  = s2_id;
  assign bus.busy    = s1_vld || s2_vld;

`ifdef AP_MULT_ERR_MON_EN
  logic [PROD_W-1:0] s2_exact;
  logic [PROD_W-1:0] diff;

  always_comb begin
    diff = (s2_exact >= s2_res) ? s2_exact - s2_res
                                : s2_res - s2_exact;
  end

  // exact product rides alongside the approximate one into S2
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_exact <= '0;
      err_cnt  <= '0;
      err_max  <= '0;
    end else begin
      if (s2_load && s1_vld)
        s2_exact <= PROD_W'(s1_muld) * PROD_W'(s1_mulr);
      if (s2_vld && bus.res_rdy) begin
        if (diff != '0 && err_cnt != '1)
          err_cnt <= err_cnt + 1'b1;
        if (diff > err_max)
          err_max <= diff;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ap_mult_sched.sv
// Randomized scoreboard bench for ap_mult_sched plus directed scenarios.
// Reference model: op queue with accept stamps and cyclic-distance RR.
module tb_ap_mult_sched;
  import ap_mult_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ap_mult_sched_if #(.NREQ(N)) bus ();

`ifdef AP_MULT_ERR_MON_EN
  logic [15:0] err_cnt;
  logic [15:0] err_max;
`endif

  ap_mult_sched #(.NREQ(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef AP_MULT_ERR_MON_EN
    ,
    .err_cnt(err_cnt),
    .err_max(err_max)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] gold(input logic [7:0] a,
                                       input logic [7:0] b);
    int hi;
    logic [6:0] lo;
    hi = 0;
    lo = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j]) begin
          if (i + j >= 7) hi += (1 << (i + j));
          else lo[i+j] = 1'b1;
        end
    return 16'(hi) + 16'(lo);
  endfunction

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    int         t;
  } op_t;

  op_t         q[$];
  op_t         op;
  int          grants[$];
  int          ptr_m = N - 1;
  int          cyc = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_res;
  logic [1:0]  prev_id;
  int          ecnt = 0;
  int          emax = 0;
  bit          evld;
  bit          can;
  int          best;
  int          bd;
  int          d;
  int          ex;
  logic [N-1:0] exp_rdy;

  always @(negedge clk) begin
    if (rst) begin
      check("rdy_in_rst", bus.req_rdy, '0);
      q.delete();
      ptr_m      = N - 1;
      prev_stall = 0;
      ecnt       = 0;
      emax       = 0;
    end else begin
      evld = q.size() > 0 && q[0].t + 2 <= cyc;
      check("res_vld", bus.res_vld, evld);
      check("busy", bus.busy, q.size() > 0);
      can = q.size() < 2 || bus.res_rdy;
      best = -1;
      bd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - ptr_m - 1 + N) % N;
        if (bus.req_vld[i] && d < bd) begin
          bd = d;
          best = i;
        end
      end
      exp_rdy = '0;
      if (can && best >= 0) exp_rdy[best] = 1'b1;
      check("req_rdy", bus.req_rdy, exp_rdy);
      if (prev_stall) begin
        check("res_hold", bus.res, prev_res);
        check("id_hold", bus.res_id, prev_id);
      end
      if (evld && bus.res_rdy) begin
        op = q.pop_front();
        check("res", bus.res, gold(op.a, op.b));
        check("res_id", bus.res_id, op.id);
        ex = int'(op.a) * int'(op.b);
        d  = ex - int'(gold(op.a, op.b));
        if (d < 0) d = -d;
        if (d != 0 && ecnt < 65535) ecnt++;
        if (d > emax) emax = d;
      end
      if (best >= 0 && can) begin
        op.id = best;
        op.a  = bus.req_muld[best*8 +: 8];
        op.b  = bus.req_mulr[best*8 +: 8];
        op.t  = cyc;
        q.push_back(op);
        grants.push_back(best);
        ptr_m = best;
      end
      prev_stall = bus.res_vld && !bus.res_rdy;
      prev_res   = bus.res;
      prev_id    = bus.res_id;
    end
    cyc++;
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int n0;

  initial begin
    rst = 1'b1;
    bus.req_vld  = '0;
    bus.req_muld = '0;
    bus.req_mulr = '0;
    bus.res_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_res", bus.res, 16'd0);
    check("rst_id", bus.res_id, 2'd0);

    // single request from requester 2
    bus.req_muld = 32'h0012_0000;
    bus.req_mulr = 32'h0034_0000;
    bus.req_vld  = 4'b0100;
    @(posedge clk);
    #1 bus.req_vld = '0;
    @(negedge clk);
    check("lat_early", bus.res_vld, 1'b0);
    @(negedge clk);
    check("lat_vld", bus.res_vld, 1'b1);
    check("lat_id", bus.res_id, 2'd2);
    check("lat_res", bus.res, gold(8'h12, 8'h34));
    repeat (3) @(posedge clk);

    // all requesters active right after reset
    do_reset();
    grants.delete();
    bus.req_muld = 32'($urandom);
    bus.req_mulr = 32'($urandom);
    bus.req_vld  = '1;
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.req_muld = 32'($urandom);
      bus.req_mulr = 32'($urandom);
    end
    @(posedge clk);
    #1 bus.req_vld = '0;
    check("rr_cnt", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check("rr_order", grants[i], i % N);
    repeat (4) @(posedge clk);

    // backpressure: consumer stalls
    n0 = grants.size();
    #1;
    bus.res_rdy = 1'b0;
    bus.req_vld = '1;
    repeat (5) @(posedge clk);
    #1;
    check("bp_accepted", grants.size() - n0, 2);
    check("bp_rdy", bus.req_rdy, '0);
    bus.req_vld = '0;
    bus.res_rdy = 1'b1;
    repeat (6) @(posedge clk);

    // reset with two operations in flight
    #1 bus.req_vld = '1;
    repeat (2) @(posedge clk);
    #1;
    bus.req_vld = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_flight_vld", bus.res_vld, 1'b0);
    check("rst_flight_busy", bus.busy, 1'b0);
    bus.req_vld = '1;
    #1 check("rst_first_gnt", bus.req_rdy, 4'b0001);
    @(posedge clk);
    #1 bus.req_vld = '0;
    repeat (4) @(posedge clk);

    // random traffic
    do_reset();
    repeat (10000) begin
      @(posedge clk);
      #1;
      bus.req_vld  = N'($urandom);
      bus.req_muld = 32'($urandom);
      bus.req_mulr = 32'($urandom);
      bus.res_rdy  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    bus.req_vld = '0;
    bus.res_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
    check("drain_busy", bus.busy, 1'b0);
`ifdef AP_MULT_ERR_MON_EN
    check("err_cnt", err_cnt, ecnt);
    check("err_max", err_max, emax);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
